// File: rtl/regfile_write_queue.sv
// regfile_write_queue
//   Write-back buffer in front of the 32 x 32-bit register file. Write
//   requests from the write-back stage are queued in order, and then retired
//   one per granted write slot. Each retirement is a registered one-hot write
//   enable plus data. Read-side hazard lookup reports whether a register still
//   has a write pending.
//
//   Optional feature macro: WB_BYPASS_EN. When it is defined, the youngest
//   pending data for Rd_Addr is forwarded on Rd_Fwd_Data. When it is not
//   defined, Rd_Fwd_Valid and Rd_Fwd_Data are tied to 0.
//
// Parameters
//   DEPTH   queue entries (power of two, 2..16)
//   ADDR_W  register address width
//   DATA_W  register data width
//
// Ports
//   Clk           clock, rising edge
//   Reset         asynchronous reset, active low
//   In_Valid      write request present
//   In_Ready      queue can accept a request (depends only on the registered count)
//   In_Addr       destination register of the request
//   In_Data       data of the request
//   Drain_En      register file write slot granted this cycle
//   RF_WE         registered one-hot write enable, one bit per register
//   RF_Data       registered write data presented to all registers
//   Rd_Addr       read address to check for pending writes
//   Rd_Pending    a write to Rd_Addr is queued or in flight
//   Rd_Fwd_Valid  Rd_Fwd_Data is valid (bypass build only)
//   Rd_Fwd_Data   youngest pending data for Rd_Addr (bypass build only)
//   Count         number of queued entries
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  input  logic [ADDR_W-1:0]         In_Addr,
  input  logic [DATA_W-1:0]         In_Data,
  input  logic                      Drain_En,
  output logic [(2**ADDR_W)-1:0]    RF_WE,
  output logic [DATA_W-1:0]         RF_Data,
  input  logic [ADDR_W-1:0]         Rd_Addr,
  output logic                      Rd_Pending,
  output logic                      Rd_Fwd_Valid,
  output logic [DATA_W-1:0]         Rd_Fwd_Data,
  output logic [$clog2(DEPTH):0]    Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2 ** ADDR_W;

  // Entry storage. Hazard lookup compares every slot at the same time, so
  // these arrays are plain registers and are read without a clock.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [NREG-1:0]   rf_we_reg;
  logic [DATA_W-1:0] rf_data_reg;

  logic              enq_fire;
  logic              store;
  logic              deq;
  logic [DEPTH-1:0]  slot_hit;
  logic              rd_pending;

  assign In_Ready = (count_reg < CNT_W'(DEPTH));
  assign enq_fire = In_Valid && In_Ready;
  // Writes to r0 complete the handshake, but they are dropped here. They
  // never occupy a slot.
  assign store    = enq_fire && (In_Addr != '0);
  // Drain uses the registered count. An entry that is enqueued on this edge
  // cannot drain before the next edge.
  assign deq      = Drain_En && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    case ({store, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rf_we_reg   <= '0;
      rf_data_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (store) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (deq) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rf_we_reg   <= {{(NREG-1){1'b0}}, 1'b1} << addr_mem[rd_ptr_reg];
        rf_data_reg <= data_mem[rd_ptr_reg];
      end else begin
        rf_we_reg <= '0;
      end
    end
  end

  // Slot contents are only meaningful while the slot is inside the valid
  // window, so they are not cleared on reset.
  always_ff @(posedge Clk) begin
    if (store) begin
      addr_mem[wr_ptr_reg] <= In_Addr;
      data_mem[wr_ptr_reg] <= In_Data;
    end
  end

  // A slot is live when its distance from the head is less than the count.
  // The subtraction wraps modulo DEPTH, so this check also works after the
  // pointers have wrapped.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] age;
      assign age          = PTR_W'(gi) - rd_ptr_reg;
      assign slot_hit[gi] = ({1'b0, age} < count_reg) && (addr_mem[gi] == Rd_Addr);
    end
  endgenerate

  assign rd_pending = (Rd_Addr != '0) && ((|slot_hit) || rf_we_reg[Rd_Addr]);

  assign RF_WE      = rf_we_reg;
  assign RF_Data    = rf_data_reg;
  assign Count      = count_reg;
  assign Rd_Pending = rd_pending;

`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  // The scan runs from oldest to newest, and a later hit overrides an earlier
  // one, so the youngest queued write wins. The in-flight RF_Data is the
  // starting value. It is used only when no queued entry matches.
  always_comb begin
    fwd_data = rf_data_reg;
    fwd_idx  = rd_ptr_reg;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_reg + PTR_W'(k);
      if (slot_hit[fwd_idx]) begin
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

  assign Rd_Fwd_Valid = rd_pending;
  assign Rd_Fwd_Data  = rd_pending ? fwd_data : '0;
`else
  assign Rd_Fwd_Valid = 1'b0;
  assign Rd_Fwd_Data  = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
module tb_regfile_write_queue;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Reset;
  logic        In_Valid;
  logic        In_Ready;
  logic [4:0]  In_Addr;
  logic [31:0] In_Data;
  logic        Drain_En;
  logic [31:0] RF_WE;
  logic [31:0] RF_Data;
  logic [4:0]  Rd_Addr;
  logic        Rd_Pending;
  logic        Rd_Fwd_Valid;
  logic [31:0] Rd_Fwd_Data;
  logic [2:0]  Count;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of pending writes, plus the write that was retired last.
  logic [4:0]  mq_addr[$];
  logic [31:0] mq_data[$];
  logic [31:0] m_we;
  logic [31:0] m_rfdata;

  regfile_write_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Addr(In_Addr), .In_Data(In_Data), .Drain_En(Drain_En),
    .RF_WE(RF_WE), .RF_Data(RF_Data), .Rd_Addr(Rd_Addr),
    .Rd_Pending(Rd_Pending), .Rd_Fwd_Valid(Rd_Fwd_Valid),
    .Rd_Fwd_Data(Rd_Fwd_Data), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic bit exp_pending(input logic [4:0] rd);
    if (rd == 5'd0) return 1'b0;
    foreach (mq_addr[i]) if (mq_addr[i] == rd) return 1'b1;
    return m_we[rd];
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] rd);
    for (int i = mq_addr.size() - 1; i >= 0; i--)
      if (mq_addr[i] == rd) return mq_data[i];
    if (rd != 5'd0 && m_we[rd]) return m_rfdata;
    return 32'd0;
  endfunction

  task automatic model_clear();
    mq_addr.delete();
    mq_data.delete();
    m_we = 32'd0;
    m_rfdata = 32'd0;
  endtask

  // Applies one cycle of stimulus, then moves to the next falling edge.
  // The reference model is updated from the state it had before the edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d, input logic dr);
    bit acc, pop;
    In_Valid = v; In_Addr = a; In_Data = d; Drain_En = dr;
    acc = v && (mq_addr.size() < DEPTH);
    pop = dr && (mq_addr.size() > 0);
    @(posedge Clk);
    if (pop) begin
      m_we = 32'h1 << mq_addr[0];
      m_rfdata = mq_data[0];
      $display("[%0t] drain r%0d data=%08h", $time, mq_addr[0], mq_data[0]);
      void'(mq_addr.pop_front());
      void'(mq_data.pop_front());
    end else begin
      m_we = 32'd0;
    end
    if (acc) begin
      $display("[%0t] enq   r%0d data=%08h", $time, a, d);
      if (a != 5'd0) begin
        mq_addr.push_back(a);
        mq_data.push_back(d);
      end
    end
    @(negedge Clk);
    In_Valid = 1'b0; Drain_En = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] we_before;
    Reset = 1'b0; In_Valid = 0; In_Addr = 0; In_Data = 0; Drain_En = 0; Rd_Addr = 0;
    model_clear();
    repeat (2) @(negedge Clk);
    total++; if (Count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", Count); end
    total++; if (RF_WE !== 32'd0 || RF_Data !== 32'd0) begin bad++; $display("FAIL rst_rf got we=%h data=%h exp 0/0", RF_WE, RF_Data); end
    total++; if (Rd_Pending !== 1'b0 || Rd_Fwd_Valid !== 1'b0 || Rd_Fwd_Data !== 32'd0) begin bad++; $display("FAIL rst_rd got pend=%b fv=%b fd=%h exp 0", Rd_Pending, Rd_Fwd_Valid, Rd_Fwd_Data); end
    Reset = 1'b1;
    #1;
    total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", In_Ready); end
    @(negedge Clk);
    // Queue three entries, and then retire one while a fourth is enqueued.
    // After this, Count=3 and RF_WE is nonzero.
    step(1, 5'd3, 32'h33, 0);
    step(1, 5'd4, 32'h44, 0);
    step(1, 5'd6, 32'h66, 0);
    step(1, 5'd9, 32'h99, 1);
    we_before = RF_WE;
    total++; if (Count !== 3'd3 || we_before !== 32'h8) begin bad++; $display("FAIL pre_rst got cnt=%0d we=%h exp 3/00000008", Count, we_before); end
    #2 Reset = 1'b0;
    model_clear();
    #1;
    total++; if (Count !== 3'd0 || RF_WE !== 32'd0) begin bad++; $display("FAIL async_rst got cnt=%0d we=%h exp 0/0", Count, RF_WE); end
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", In_Ready); end
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      step(0, 5'd0, 32'd0, 1);
      total++; if (RF_WE !== 32'd0 || Count !== 3'd0) begin bad++; $display("FAIL post_rst_drain got we=%h cnt=%0d exp 0/0", RF_WE, Count); end
    end
  endtask

  task automatic test_latency();
    step(1, 5'd5, 32'hDEADBEEF, 1);
    total++; if (RF_WE !== 32'd0 || Count !== 3'd1) begin bad++; $display("FAIL lat_edgeN got we=%h cnt=%0d exp 0/1", RF_WE, Count); end
    step(0, 5'd0, 32'd0, 1);
    total++; if (RF_WE !== 32'h20 || RF_Data !== 32'hDEADBEEF) begin bad++; $display("FAIL lat_pulse got we=%h data=%h exp 00000020/deadbeef", RF_WE, RF_Data); end
    step(0, 5'd0, 32'd0, 1);
    total++; if (RF_WE !== 32'd0 || Count !== 3'd0) begin bad++; $display("FAIL lat_end got we=%h cnt=%0d exp 0/0", RF_WE, Count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) step(1, 5'(i + 1), 32'hA0 + 32'(i), 0);
    total++; if (Count !== 3'd4 || In_Ready !== 1'b0) begin bad++; $display("FAIL full got cnt=%0d rdy=%b exp 4/0", Count, In_Ready); end
    step(1, 5'd5, 32'hA4, 0);
    total++; if (Count !== 3'd4 || RF_WE !== 32'd0) begin bad++; $display("FAIL full_hold got cnt=%0d we=%h exp 4/0", Count, RF_WE); end
    step(1, 5'd5, 32'hA4, 1);
    total++; if (Count !== 3'd3 || RF_WE !== 32'h2 || RF_Data !== 32'hA0) begin bad++; $display("FAIL full_drain got cnt=%0d we=%h d=%h exp 3/00000002/a0", Count, RF_WE, RF_Data); end
    step(1, 5'd5, 32'hA4, 0);
    total++; if (Count !== 3'd4) begin bad++; $display("FAIL full_refill got cnt=%0d exp 4", Count); end
    for (int i = 1; i < 5; i++) begin
      step(0, 5'd0, 32'd0, 1);
      total++; if (RF_WE !== (32'h1 << (i + 1)) || RF_Data !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL full_order%0d got we=%h d=%h exp %h/%h", i, RF_WE, RF_Data, 32'h1 << (i + 1), 32'hA0 + 32'(i)); end
    end
    step(0, 5'd0, 32'd0, 0);
  endtask

  task automatic test_r0();
    total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b exp=1", In_Ready); end
    step(1, 5'd0, 32'h12345678, 0);
    total++; if (Count !== 3'd0) begin bad++; $display("FAIL r0_count got=%0d exp=0", Count); end
    for (int i = 0; i < 3; i++) begin
      step(0, 5'd0, 32'd0, 1);
      total++; if (RF_WE !== 32'd0) begin bad++; $display("FAIL r0_we got=%h exp=0", RF_WE); end
    end
  endtask

  task automatic test_pending();
    step(1, 5'd7, 32'h1, 0);
    step(1, 5'd7, 32'h2, 0);
    Rd_Addr = 5'd7;
    #1;
    total++; if (Rd_Pending !== 1'b1) begin bad++; $display("FAIL pend_q got=%b exp=1", Rd_Pending); end
`ifdef WB_BYPASS_EN
    total++; if (Rd_Fwd_Valid !== 1'b1 || Rd_Fwd_Data !== 32'h2) begin bad++; $display("FAIL fwd_q got v=%b d=%h exp 1/2", Rd_Fwd_Valid, Rd_Fwd_Data); end
`else
    total++; if (Rd_Fwd_Valid !== 1'b0 || Rd_Fwd_Data !== 32'h0) begin bad++; $display("FAIL fwd_tied got v=%b d=%h exp 0/0", Rd_Fwd_Valid, Rd_Fwd_Data); end
`endif
    step(0, 5'd0, 32'd0, 1);
    step(0, 5'd0, 32'd0, 1);
    total++; if (Rd_Pending !== 1'b1 || RF_WE !== 32'h80) begin bad++; $display("FAIL pend_inflight got p=%b we=%h exp 1/00000080", Rd_Pending, RF_WE); end
`ifdef WB_BYPASS_EN
    total++; if (Rd_Fwd_Data !== 32'h2) begin bad++; $display("FAIL fwd_inflight got=%h exp=2", Rd_Fwd_Data); end
`endif
    step(0, 5'd0, 32'd0, 1);
    total++; if (Rd_Pending !== 1'b0) begin bad++; $display("FAIL pend_clear got=%b exp=0", Rd_Pending); end
    Rd_Addr = 5'd0;
  endtask

  task automatic test_wrap();
    logic [4:0]  sa[11];
    logic [31:0] sd[11];
    for (int i = 0; i < 11; i++) begin sa[i] = 5'(i % 6 + 1); sd[i] = 32'hC000 + 32'(i); end
    step(1, sa[0], sd[0], 0);
    for (int k = 0; k < 10; k++) begin
      step(1, sa[k + 1], sd[k + 1], 1);
      total++; if (Count !== 3'd1 || RF_WE !== (32'h1 << sa[k]) || RF_Data !== sd[k]) begin bad++; $display("FAIL wrap%0d got cnt=%0d we=%h d=%h exp 1/%h/%h", k, Count, RF_WE, RF_Data, 32'h1 << sa[k], sd[k]); end
    end
    step(0, 5'd0, 32'd0, 1);
    step(0, 5'd0, 32'd0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      Rd_Addr = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 2) == 0));
      total++; if (Count !== 3'(mq_addr.size()) || In_Ready !== (mq_addr.size() < DEPTH)) begin bad++; $display("FAIL rnd_cnt[%0d] got cnt=%0d rdy=%b exp %0d", n, Count, In_Ready, mq_addr.size()); end
      total++; if (RF_WE !== m_we || RF_Data !== m_rfdata) begin bad++; $display("FAIL rnd_rf[%0d] got we=%h d=%h exp %h/%h", n, RF_WE, RF_Data, m_we, m_rfdata); end
      total++; if (Rd_Pending !== exp_pending(Rd_Addr)) begin bad++; $display("FAIL rnd_pend[%0d] rd=%0d got=%b exp=%b", n, Rd_Addr, Rd_Pending, exp_pending(Rd_Addr)); end
`ifdef WB_BYPASS_EN
      if (exp_pending(Rd_Addr)) begin
        total++; if (Rd_Fwd_Valid !== 1'b1 || Rd_Fwd_Data !== exp_fwd(Rd_Addr)) begin bad++; $display("FAIL rnd_fwd[%0d] got v=%b d=%h exp 1/%h", n, Rd_Fwd_Valid, Rd_Fwd_Data, exp_fwd(Rd_Addr)); end
      end
`else
      total++; if (Rd_Fwd_Valid !== 1'b0 || Rd_Fwd_Data !== 32'd0) begin bad++; $display("FAIL rnd_fwd_tied[%0d] got v=%b d=%h", n, Rd_Fwd_Valid, Rd_Fwd_Data); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_r0();
    test_pending();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-back buffer that sits directly upstream of the 32 x 32-bit register file and drives its per-register write enables and write data.
- Accepts (destination address, data) write requests from the write-back stage through a valid/ready handshake.
- Holds up to DEPTH requests in order and retires one per cycle into the register file when a write slot is granted.
- Reports to the decode/read stage whether a read address has a write still pending.

Parameters:
DEPTH, 4, queue entries (power of two, 2..16)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
Clk  in  1  clock; all state updates on posedge only
Reset  in  1  asynchronous reset, active-low; clears all state immediately
In_Valid  in  1  write request present
In_Ready  out  1  queue can accept a request this cycle
In_Addr  in  ADDR_W  destination register
In_Data  in  DATA_W  data to write
Drain_En  in  1  register file write slot granted this cycle
RF_WE  out  2**ADDR_W  one-hot write enable, one bit per register
RF_Data  out  DATA_W  data presented to all registers
Rd_Addr  in  ADDR_W  read address to check
Rd_Pending  out  1  a write to Rd_Addr is queued or in flight
Rd_Fwd_Valid  out  1  Rd_Fwd_Data is valid (feature only)
Rd_Fwd_Data  out  DATA_W  youngest pending data for Rd_Addr (feature only)
Count  out  clog2(DEPTH)+1  current number of queued entries

Behaviour:
- Reset (Reset=0, async): pointers=0, Count=0, RF_WE=0, RF_Data=0, In_Ready=1 as soon as Reset deasserts, Rd_Pending=0, Rd_Fwd_Valid=0, Rd_Fwd_Data=0.
- Reset asserted mid-operation: every queued and in-flight write is discarded; no RF_WE pulse after reset.
- In_Ready = (Count < DEPTH); combinational from registered Count only, never from In_Valid.
- Enqueue: In_Valid && In_Ready at a posedge writes {In_Addr, In_Data} at the write pointer, and the write pointer increments modulo DEPTH.
- Enqueue to address 0: handshake completes (accepted) but nothing is stored and Count is unchanged; r0 is never written.
- Drain: Drain_En && Count>0 at a posedge pops the head entry, and the read pointer increments modulo DEPTH.
- On that same edge, the output register loads RF_WE = one-hot(head addr) and RF_Data = head data.
- Otherwise RF_WE loads 0 and RF_Data holds its value.
- RF_WE is therefore a single-cycle pulse, registered, and never has more than one bit set.
- Latency: request accepted at edge N -> earliest drain at edge N+1 -> RF_WE high during cycle N+1..N+2. There is no same-cycle pass-through.
- Simultaneous enqueue and drain: Count unchanged, both pointers advance.
- Enqueue when Count=0 with Drain_En=1 on the same edge: only the enqueue takes effect.
- Drain_En with Count=0: no effect, RF_WE=0.
- In_Valid while full: not accepted; the request must be held by the source and nothing changes.
- Pointer wrap: pointers are ADDR-free counters of width clog2(DEPTH), wrapping DEPTH-1 -> 0. Full/empty is derived from Count only.
- Rd_Pending (combinational) = Rd_Addr!=0 AND (any valid queue entry has addr==Rd_Addr OR the RF_WE bit for Rd_Addr is set).

Optional Feature:
Macro WB_BYPASS_EN.
- Defined:
  - Rd_Fwd_Valid = Rd_Pending.
  - Rd_Fwd_Data = data of the youngest matching entry. Search order: newest queue entry to oldest, then the in-flight RF_Data.
  - All combinational.
- Undefined:
  - Rd_Fwd_Valid and Rd_Fwd_Data are tied to 0.
  - No comparator/mux tree is synthesised; Rd_Pending is still produced.

Test Plan:
1. Reset low mid-queue with Count=3 -> Count=0, RF_WE=0 immediately; after release In_Ready=1 and no RF_WE pulse follows.
2. Enqueue (5,0xDEADBEEF) at edge N, Drain_En=1 from edge N -> RF_WE=0x00000020, RF_Data=0xDEADBEEF for exactly one cycle after edge N+1.
3. Enqueue 4 writes with Drain_En=0 -> Count=4, In_Ready=0; fifth request held; one drain -> Count=4 next edge with the fifth accepted, order preserved.
4. Enqueue (0,0x12345678) -> accepted, Count stays 0, no RF_WE pulse ever.
5. Enqueue (7,0x1) then (7,0x2), Rd_Addr=7 -> Rd_Pending=1. With WB_BYPASS_EN: Rd_Fwd_Data=0x2; after both drains, Rd_Pending=0.
6. Continuous enqueue + drain for 10 cycles at DEPTH=4 -> pointers wrap, Count constant at 1, RF_WE sequence matches input order.
